// File: rtl/image_sort_pkg.sv
// Shared types for the image sort engine: colour codes, table entry and FSM states.
package image_sort_pkg;

   typedef enum logic [1:0] {
      COL_R = 2'd0,
      COL_G = 2'd1,
      COL_B = 2'd2
   } color_e;

   // Entry fields are sized for the largest supported configuration; narrower
   // configurations leave the upper bits at zero.
   localparam int ENTRY_MEAN_W = 32;
   localparam int ENTRY_IDX_W  = 16;

   typedef struct packed {
      color_e                  color;
      logic [ENTRY_MEAN_W-1:0] mean;
      logic [ENTRY_IDX_W-1:0]  index;
   } entry_t;

   typedef enum logic [2:0] {
      ST_ACCUM  = 3'd0,
      ST_DIV    = 3'd1,
      ST_FIND   = 3'd2,
      ST_SHIFT  = 3'd3,
      ST_INSERT = 3'd4,
      ST_OUT    = 3'd5
   } state_e;

   // True when stored entry e sorts strictly after new entry n. Equal keys are
   // not "after", so a new entry lands behind all of its equals (stable order).
   function automatic logic entry_after(input entry_t e, input entry_t n, input logic desc);
      logic after;
      if (e.color != n.color) begin
         after = (e.color > n.color);
      end else if (desc) begin
         after = (e.mean < n.mean);
      end else begin
         after = (e.mean > n.mean);
      end
      return after;
   endfunction

endpackage

// File: rtl/seq_divider.sv
// Restoring divider, one quotient bit per clock. A zero divisor yields quotient 0.
// start_i loads the operands; done_o pulses for one cycle when quotient_o is final,
// and quotient_o then holds until the next start.
module seq_divider #(
   parameter int DVD_W = 16,
   parameter int DVS_W = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start_i,
   input  logic [DVD_W-1:0] dividend_i,
   input  logic [DVS_W-1:0] divisor_i,
   output logic             done_o,
   output logic [DVD_W-1:0] quotient_o
);

   localparam int STEP_W = $clog2(DVD_W + 1);

   logic [DVD_W-1:0]  shf_q;
   logic [DVS_W-1:0]  rem_q;
   logic [DVS_W-1:0]  dvs_q;
   logic [STEP_W-1:0] step_q;
   logic              run_q;
   logic              zero_q;
   logic              done_q;

   logic [DVS_W:0]    trial_d;
   logic              fits_d;
   logic [DVS_W-1:0]  rem_d;

   // One restoring step: bring down the next dividend bit and subtract if it fits.
   always_comb begin
      trial_d = {rem_q, shf_q[DVD_W-1]};
      fits_d  = (trial_d >= {1'b0, dvs_q});
      rem_d   = trial_d[DVS_W-1:0];
      if (fits_d) begin
         rem_d = DVS_W'(trial_d - {1'b0, dvs_q});
      end
   end

   // Iteration control: the dividend shifts out the top while quotient bits shift in.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         shf_q  <= '0;
         rem_q  <= '0;
         dvs_q  <= '0;
         step_q <= '0;
         run_q  <= 1'b0;
         zero_q <= 1'b0;
         done_q <= 1'b0;
      end else begin
         done_q <= 1'b0;
         if (start_i) begin
            shf_q  <= dividend_i;
            rem_q  <= '0;
            dvs_q  <= divisor_i;
            zero_q <= (divisor_i == '0);
            step_q <= STEP_W'(DVD_W);
            run_q  <= 1'b1;
         end else if (run_q) begin
            shf_q  <= {shf_q[DVD_W-2:0], fits_d};
            rem_q  <= rem_d;
            step_q <= step_q - STEP_W'(1);
            if (step_q == STEP_W'(1)) begin
               run_q  <= 1'b0;
               done_q <= 1'b1;
            end
         end
      end
   end

   assign done_o     = done_q;
   assign quotient_o = zero_q ? '0 : shf_q;

endmodule

// File: rtl/image_sort_engine.sv
// Image sort engine: classifies streamed RGB pixels per image, derives each image's
// dominant colour and fixed-point mean of that colour, keeps a stable insertion-sorted
// table and replays it on a valid/ready port.
//
// Output handshake: an entry transfers on a clock edge where out_valid && out_ready;
// while out_valid=1 and out_ready=0 all output fields hold stable, and out_valid never
// drops without a transfer.
module image_sort_engine
   import image_sort_pkg::*;
#(
   parameter int NUM_IMG     = 32,
   parameter int PIX_PER_IMG = 16384,
   parameter int CH_W        = 8,
   parameter int FRAC_W      = 3,
   parameter int IDX_W       = $clog2(NUM_IMG)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              in_valid,
   input  logic [IDX_W-1:0]  image_in_index,
   input  logic [3*CH_W-1:0] pixel_in,
   input  logic              desc_mode,
   output logic              busy,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [1:0]        color_index,
   output logic [IDX_W-1:0]  image_out_index,
   output logic              out_last
);

   localparam int PIX_W = $clog2(PIX_PER_IMG);
   localparam int CNT_W = PIX_W + 1;
   localparam int SUM_W = CH_W + PIX_W;
   localparam int DVD_W = SUM_W + FRAC_W;
   localparam int TC_W  = IDX_W + 1;
   localparam logic [TC_W-1:0] TC_ONE = TC_W'(1);

   state_e           state_q;
   logic             busy_q;
   logic [CNT_W-1:0] pix_cnt_q;
   logic [CNT_W-1:0] cnt_q [3];
   logic [SUM_W-1:0] sum_q [3];
   logic [IDX_W-1:0] cur_idx_q;
   logic             desc_q;
   logic             div_run_q;
   entry_t           new_q;
   entry_t           table_q [NUM_IMG];
   logic [TC_W-1:0]  tbl_cnt_q;
   logic [TC_W-1:0]  ptr_q;
   logic [TC_W-1:0]  ins_q;
   logic [TC_W-1:0]  out_ptr_q;
   logic             out_valid_q;
   logic             out_last_q;
   color_e           out_col_q;
   logic [IDX_W-1:0] out_idx_q;

   logic [CH_W-1:0]  pix_r, pix_g, pix_b;
   color_e           pix_col_d;
   logic [CH_W-1:0]  pix_ch_d;
   color_e           img_col_d;
   logic             px_acc;
   logic             div_start;
   logic             div_done;
   logic [DVD_W-1:0] div_dividend_d;
   logic [CNT_W-1:0] div_divisor_d;
   logic [DVD_W-1:0] div_quot;
   logic [TC_W-1:0]  out_sel_d;

   assign pix_r  = pixel_in[3*CH_W-1 -: CH_W];
   assign pix_g  = pixel_in[2*CH_W-1 -: CH_W];
   assign pix_b  = pixel_in[CH_W-1:0];
   assign px_acc = in_valid && !busy_q;

   // Pixel classification: ties favour R over G and G over B.
   always_comb begin
      pix_col_d = COL_B;
      pix_ch_d  = pix_b;
      if (pix_r >= pix_g && pix_r >= pix_b) begin
         pix_col_d = COL_R;
         pix_ch_d  = pix_r;
      end else if (pix_g > pix_r && pix_g >= pix_b) begin
         pix_col_d = COL_G;
         pix_ch_d  = pix_g;
      end
   end

   // Image colour needs a strict count majority; any tie falls through to B.
   always_comb begin
      img_col_d = COL_B;
      if (cnt_q[COL_R] > cnt_q[COL_G] && cnt_q[COL_R] > cnt_q[COL_B]) begin
         img_col_d = COL_R;
      end else if (cnt_q[COL_G] > cnt_q[COL_R] && cnt_q[COL_G] > cnt_q[COL_B]) begin
         img_col_d = COL_G;
      end
      div_dividend_d = {sum_q[img_col_d], {FRAC_W{1'b0}}};
      div_divisor_d  = cnt_q[img_col_d];
   end

   assign div_start = (state_q == ST_DIV) && !div_run_q;
   assign out_sel_d = out_valid_q ? (out_ptr_q + TC_ONE) : out_ptr_q;

   seq_divider #(
      .DVD_W (DVD_W),
      .DVS_W (CNT_W)
   ) u_div (
      .clk        (clk),
      .reset      (reset),
      .start_i    (div_start),
      .dividend_i (div_dividend_d),
      .divisor_i  (div_divisor_d),
      .done_o     (div_done),
      .quotient_o (div_quot)
   );

   // Main controller: accumulate, divide, locate insert point, shift, insert, replay.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= ST_ACCUM;
         busy_q      <= 1'b0;
         pix_cnt_q   <= '0;
         for (int c = 0; c < 3; c++) begin
            cnt_q[c] <= '0;
            sum_q[c] <= '0;
         end
         cur_idx_q   <= '0;
         desc_q      <= 1'b0;
         div_run_q   <= 1'b0;
         new_q       <= '0;
         for (int i = 0; i < NUM_IMG; i++) begin
            table_q[i] <= '0;
         end
         tbl_cnt_q   <= '0;
         ptr_q       <= '0;
         ins_q       <= '0;
         out_ptr_q   <= '0;
         out_valid_q <= 1'b0;
         out_last_q  <= 1'b0;
         out_col_q   <= COL_R;
         out_idx_q   <= '0;
      end else begin
         case (state_q)
            ST_ACCUM: begin
               if (px_acc) begin
                  cnt_q[pix_col_d] <= cnt_q[pix_col_d] + CNT_W'(1);
                  sum_q[pix_col_d] <= sum_q[pix_col_d] + SUM_W'(pix_ch_d);
                  if (pix_cnt_q == '0) begin
                     cur_idx_q <= image_in_index;
                     if (tbl_cnt_q == '0) begin
                        desc_q <= desc_mode;
                     end
                  end
                  if (pix_cnt_q == CNT_W'(PIX_PER_IMG - 1)) begin
                     pix_cnt_q <= '0;
                     busy_q    <= 1'b1;
                     state_q   <= ST_DIV;
                  end else begin
                     pix_cnt_q <= pix_cnt_q + CNT_W'(1);
                  end
               end
            end
            ST_DIV: begin
               if (!div_run_q) begin
                  div_run_q   <= 1'b1;
                  new_q.color <= img_col_d;
                  new_q.index <= ENTRY_IDX_W'(cur_idx_q);
               end else if (div_done) begin
                  div_run_q  <= 1'b0;
                  new_q.mean <= ENTRY_MEAN_W'(div_quot);
                  ptr_q      <= '0;
                  state_q    <= ST_FIND;
               end
            end
            ST_FIND: begin
               if (ptr_q == tbl_cnt_q) begin
                  ins_q   <= ptr_q;
                  state_q <= ST_INSERT;
               end else if (entry_after(table_q[ptr_q[IDX_W-1:0]], new_q, desc_q)) begin
                  ins_q   <= ptr_q;
                  ptr_q   <= tbl_cnt_q;
                  state_q <= ST_SHIFT;
               end else begin
                  ptr_q <= ptr_q + TC_ONE;
               end
            end
            ST_SHIFT: begin
               // ptr_q walks from the first free slot down to ins_q+1.
               table_q[ptr_q[IDX_W-1:0]] <= table_q[IDX_W'(ptr_q - TC_ONE)];
               if (ptr_q == ins_q + TC_ONE) begin
                  state_q <= ST_INSERT;
               end else begin
                  ptr_q <= ptr_q - TC_ONE;
               end
            end
            ST_INSERT: begin
               table_q[ins_q[IDX_W-1:0]] <= new_q;
               tbl_cnt_q <= tbl_cnt_q + TC_ONE;
               for (int c = 0; c < 3; c++) begin
                  cnt_q[c] <= '0;
                  sum_q[c] <= '0;
               end
               if (tbl_cnt_q == TC_W'(NUM_IMG - 1)) begin
                  out_ptr_q <= '0;
                  state_q   <= ST_OUT;
               end else begin
                  busy_q  <= 1'b0;
                  state_q <= ST_ACCUM;
               end
            end
            ST_OUT: begin
               // Load a slot when nothing is presented or the current one transfers.
               if (!out_valid_q || out_ready) begin
                  if (out_valid_q && out_last_q) begin
                     out_valid_q <= 1'b0;
                     out_last_q  <= 1'b0;
                     tbl_cnt_q   <= '0;
                     busy_q      <= 1'b0;
                     state_q     <= ST_ACCUM;
                  end else begin
                     out_ptr_q   <= out_sel_d;
                     out_valid_q <= 1'b1;
                     out_col_q   <= table_q[out_sel_d[IDX_W-1:0]].color;
                     out_idx_q   <= table_q[out_sel_d[IDX_W-1:0]].index[IDX_W-1:0];
                     out_last_q  <= (out_sel_d == TC_W'(NUM_IMG - 1));
                  end
               end
            end
            default: begin
               state_q <= ST_ACCUM;
            end
         endcase
      end
   end

   assign busy            = busy_q;
   assign out_valid       = out_valid_q;
   assign color_index     = out_col_q;
   assign image_out_index = out_idx_q;
   assign out_last        = out_last_q;

endmodule

// File: tb/tb_image_sort_engine.sv
// Bench for image_sort_engine (4 images x 16 pixels). A reference model computes each
// image's colour/mean, orders a batch by rank, and queues the expected output stream.
module tb_image_sort_engine;

   localparam int NUM_IMG = 4;
   localparam int PIX     = 16;
   localparam int CH_W    = 8;
   localparam int FRAC_W  = 3;
   localparam int IDX_W   = 2;
   localparam int DVD_W   = CH_W + $clog2(PIX) + FRAC_W;
   localparam int EW      = 1 + 2 + IDX_W + 32;

   localparam int PAT_BASE = 0;
   localparam int PAT_TIE  = 1;
   localparam int PAT_RAND = 2;

   logic              clk;
   logic              reset;
   logic              in_valid;
   logic [IDX_W-1:0]  image_in_index;
   logic [3*CH_W-1:0] pixel_in;
   logic              desc_mode;
   logic              busy;
   logic              out_valid;
   logic              out_ready;
   logic [1:0]        color_index;
   logic [IDX_W-1:0]  image_out_index;
   logic              out_last;

   image_sort_engine #(
      .NUM_IMG     (NUM_IMG),
      .PIX_PER_IMG (PIX),
      .CH_W        (CH_W),
      .FRAC_W      (FRAC_W),
      .IDX_W       (IDX_W)
   ) dut (
      .clk             (clk),
      .reset           (reset),
      .in_valid        (in_valid),
      .image_in_index  (image_in_index),
      .pixel_in        (pixel_in),
      .desc_mode       (desc_mode),
      .busy            (busy),
      .out_valid       (out_valid),
      .out_ready       (out_ready),
      .color_index     (color_index),
      .image_out_index (image_out_index),
      .out_last        (out_last)
   );

   // Clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;

   logic [EW-1:0]    exp_q[$];
   logic [23:0]      img_pix [PIX];
   logic [1:0]       m_col  [NUM_IMG];
   logic [31:0]      m_mean [NUM_IMG];
   logic [IDX_W-1:0] m_idx  [NUM_IMG];
   int               m_n;
   logic             m_desc;
   int               out_pos = 0;

   task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   function automatic logic [1:0] px_class(input logic [23:0] p);
      logic [7:0] r, g, b;
      r = p[23:16];
      g = p[15:8];
      b = p[7:0];
      if (r >= g && r >= b) return 2'd0;
      if (g > r && g >= b) return 2'd1;
      return 2'd2;
   endfunction

   // Reference colour/mean of the image held in img_pix.
   task automatic model_image(input logic [IDX_W-1:0] idx);
      int cnt [3];
      int sum [3];
      logic [1:0] c;
      logic [1:0] col;
      for (int j = 0; j < 3; j++) begin
         cnt[j] = 0;
         sum[j] = 0;
      end
      for (int i = 0; i < PIX; i++) begin
         c = px_class(img_pix[i]);
         cnt[c]++;
         if (c == 2'd0) sum[c] += int'(img_pix[i][23:16]);
         else if (c == 2'd1) sum[c] += int'(img_pix[i][15:8]);
         else sum[c] += int'(img_pix[i][7:0]);
      end
      if (cnt[0] > cnt[1] && cnt[0] > cnt[2]) col = 2'd0;
      else if (cnt[1] > cnt[0] && cnt[1] > cnt[2]) col = 2'd1;
      else col = 2'd2;
      if (m_n < NUM_IMG) begin
         m_col[m_n]  = col;
         m_mean[m_n] = (cnt[col] == 0) ? 32'd0 : 32'((sum[col] * (1 << FRAC_W)) / cnt[col]);
         m_idx[m_n]  = idx;
         m_n++;
      end
   endtask

   function automatic bit key_less(input int i, input int j);
      if (m_col[i] != m_col[j]) return m_col[i] < m_col[j];
      if (m_desc) return m_mean[i] > m_mean[j];
      return m_mean[i] < m_mean[j];
   endfunction

   // Expected order: rank = strictly smaller keys + earlier equal keys.
   task automatic model_batch();
      int rank [NUM_IMG];
      logic [EW-1:0] e;
      for (int i = 0; i < NUM_IMG; i++) begin
         rank[i] = 0;
         for (int j = 0; j < NUM_IMG; j++) begin
            if (j != i && key_less(j, i)) rank[i]++;
            else if (j < i && !key_less(i, j) && !key_less(j, i)) rank[i]++;
         end
      end
      for (int pos = 0; pos < NUM_IMG; pos++) begin
         for (int i = 0; i < NUM_IMG; i++) begin
            if (rank[i] == pos) begin
               e = {(pos == NUM_IMG - 1) ? 1'b1 : 1'b0, m_col[i], m_idx[i], m_mean[i]};
               exp_q.push_back(e);
            end
         end
      end
   endtask

   task automatic fill_image(input int pat, input int k, output logic [IDX_W-1:0] idx);
      int d;
      logic [23:0] p;
      d = int'($urandom_range(0, 2));
      for (int i = 0; i < PIX; i++) begin
         case (pat)
            PAT_BASE: begin
               case (k)
                  0: p = {8'd10, 8'd0, 8'd0};
                  1: p = {8'd0, 8'd20, 8'd0};
                  2: p = {8'd5, 8'd0, 8'd0};
                  default: p = {8'd0, 8'd0, 8'd7};
               endcase
            end
            PAT_TIE: begin
               case (k)
                  0: p = (i < 8) ? {8'd9, 8'd9, 8'd3} : {8'd3, 8'd9, 8'd9};
                  1: p = {8'd9, 8'd3, 8'd9};
                  default: p = {8'd0, 8'd30, 8'd0};
               endcase
            end
            default: begin
               p = 24'($urandom_range(0, 32'h00FF_FFFF));
               if ($urandom_range(0, 3) != 0) begin
                  if (d == 0) p[23:16] = 8'($urandom_range(200, 255));
                  else if (d == 1) p[15:8] = 8'($urandom_range(200, 255));
                  else p[7:0] = 8'($urandom_range(200, 255));
               end
            end
         endcase
         img_pix[i] = p;
      end
      case (pat)
         PAT_BASE: idx = IDX_W'(k);
         PAT_TIE:  idx = (k == 0) ? 2'd0 : (k == 1) ? 2'd2 : (k == 2) ? 2'd3 : 2'd1;
         default:  idx = IDX_W'($urandom_range(0, NUM_IMG - 1));
      endcase
   endtask

   // Driver: wait (bounded) for busy low, then present one pixel for one edge.
   task automatic send_pixel(input logic [23:0] p, input logic [IDX_W-1:0] idx);
      int n;
      n = 0;
      while (busy !== 1'b0 && n < 300) begin
         @(negedge clk);
         n++;
      end
      if (busy !== 1'b0) begin
         check_val("busy_timeout", 64'(busy), 64'd0);
      end else begin
         in_valid       = 1'b1;
         pixel_in       = p;
         image_in_index = idx;
         @(negedge clk);
         in_valid       = 1'b0;
      end
   endtask

   task automatic send_image(input logic [IDX_W-1:0] idx, input int k, input bit pulse);
      int n;
      int lim;
      for (int i = 0; i < PIX; i++) send_pixel(img_pix[i], idx);
      model_image(idx);
      if (k < NUM_IMG - 1) begin
         lim = DVD_W + 2 * k + 4;
         n = 0;
         while (busy === 1'b1 && n <= lim) begin
            if (pulse && n < 3) begin
               in_valid = 1'b1;
               pixel_in = 24'hFF0000;
            end else begin
               in_valid = 1'b0;
            end
            @(negedge clk);
            n++;
         end
         in_valid = 1'b0;
         check_val("latency_ok", 64'(busy === 1'b0 && n <= lim), 64'd1);
      end else begin
         model_batch();
      end
   endtask

   task automatic hold_check();
      int n;
      logic [EW-1:0] e;
      n = 0;
      while (out_valid !== 1'b1 && n < 300) begin
         @(negedge clk);
         n++;
      end
      check_val("hold_wait", 64'(out_valid), 64'd1);
      if (exp_q.size() != 0) begin
         e = exp_q[0];
         for (int c = 0; c < 5; c++) begin
            check_val("hold_valid", 64'(out_valid), 64'd1);
            check_val("hold_color", 64'(color_index), 64'(e[EW-2 -: 2]));
            check_val("hold_index", 64'(image_out_index), 64'(e[32 +: IDX_W]));
            check_val("hold_last", 64'(out_last), 64'(e[EW-1]));
            @(negedge clk);
         end
      end
      out_ready = 1'b1;
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 400) begin
         @(negedge clk);
         n++;
      end
      check_val("drain_left", 64'(exp_q.size()), 64'd0);
      @(negedge clk);
      check_val("post_busy", 64'(busy), 64'd0);
      check_val("post_valid", 64'(out_valid), 64'd0);
   endtask

   task automatic run_batch(input bit desc, input int pat, input bit hold, input bit pulse);
      logic [IDX_W-1:0] idx;
      m_n       = 0;
      m_desc    = desc;
      desc_mode = desc;
      for (int k = 0; k < NUM_IMG; k++) begin
         fill_image(pat, k, idx);
         if (hold && k == NUM_IMG - 1) out_ready = 1'b0;
         send_image(idx, k, pulse && (k == 0));
      end
      if (hold) hold_check();
      drain();
   endtask

   // Reset block: asynchronous assert, all outputs checked low while held.
   task automatic do_reset();
      @(negedge clk);
      reset    = 1'b1;
      in_valid = 1'b0;
      #2;
      check_val("rst_busy", 64'(busy), 64'd0);
      @(negedge clk);
      check_val("rst_valid", 64'(out_valid), 64'd0);
      check_val("rst_last", 64'(out_last), 64'd0);
      check_val("rst_color", 64'(color_index), 64'd0);
      check_val("rst_index", 64'(image_out_index), 64'd0);
      exp_q.delete();
      m_n = 0;
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
   endtask

   // Scoreboard: compare each transferring entry against the head of the queue.
   always @(negedge clk) begin
      logic [EW-1:0] e;
      if (reset) begin
         out_pos = 0;
      end else if (out_valid === 1'b1 && out_ready === 1'b1) begin
         if (exp_q.size() == 0) begin
            check_val("unexpected_out", 64'd1, 64'd0);
         end else begin
            e = exp_q.pop_front();
            check_val("out_color", 64'(color_index), 64'(e[EW-2 -: 2]));
            check_val("out_index", 64'(image_out_index), 64'(e[32 +: IDX_W]));
            check_val("out_last", 64'(out_last), 64'(e[EW-1]));
            check_val("out_mean", 64'(dut.table_q[out_pos % NUM_IMG].mean), 64'(e[31:0]));
            out_pos = e[EW-1] ? 0 : out_pos + 1;
         end
      end
   end

   initial begin
      logic [IDX_W-1:0] idx;
      reset          = 1'b1;
      in_valid       = 1'b0;
      pixel_in       = '0;
      image_in_index = '0;
      desc_mode      = 1'b0;
      out_ready      = 1'b1;
      m_n            = 0;
      m_desc         = 1'b0;
      do_reset();

      // Ascending means; junk in_valid pulses while busy after image 0.
      run_batch(1'b0, PAT_BASE, 1'b0, 1'b1);
      // Descending means with back-pressure on the first entry.
      run_batch(1'b1, PAT_BASE, 1'b1, 1'b0);
      // Classification ties and stability of equal keys.
      run_batch(1'b0, PAT_TIE, 1'b0, 1'b0);

      // Abort mid-batch: two images and seven pixels, then reset.
      m_n = 0;
      desc_mode = 1'b0;
      for (int k = 0; k < 2; k++) begin
         fill_image(PAT_BASE, k, idx);
         send_image(idx, k, 1'b0);
      end
      fill_image(PAT_BASE, 2, idx);
      for (int i = 0; i < 7; i++) send_pixel(img_pix[i], idx);
      do_reset();

      run_batch(1'($urandom_range(0, 1)), PAT_RAND, 1'b0, 1'b0);
      run_batch(1'($urandom_range(0, 1)), PAT_RAND, 1'b1, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
